sync_fifo_ctl: RTL and testbench
================================

// Module: sync_fifo_ctl
// PURPOSE
//  Single-clock, parametrised FIFO: the successor to the dual-clock pointer FIFO, for paths where
//  producer and consumer share clk (e.g. FT600 packet staging). Adds fill level, programmable
//  almost-full/almost-empty, selectable first-word-fall-through (FWFT), flush, and overflow/underflow pulses.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits
//  ADDR_WIDTH  4   log2(depth); DEPTH = 1<<ADDR_WIDTH, >=2
//  FWFT        0   0 = standard read (registered r_out); 1 = first-word-fall-through
//  AF_THRESH   DEPTH-2  w_almost_full asserted when level >= AF_THRESH (range 1..DEPTH)
//  AE_THRESH   1        r_almost_empty asserted when level <= AE_THRESH (range 0..DEPTH-1)
// PORTS
//  clk             in   1             single clock; all logic on posedge
//  rst_n           in   1             synchronous reset, active low
//  flush           in   1             synchronous clear of contents, active high
//  w_en            in   1             write request
//  w_in            in   DATA_WIDTH    write data
//  w_full          out  1             level == DEPTH
//  w_almost_full   out  1             level >= AF_THRESH
//  overflow        out  1             1-cycle pulse: write request rejected
//  r_en            in   1             read request (FWFT=1: pop/acknowledge)
//  r_out           out  DATA_WIDTH    read data
//  r_empty         out  1             level == 0
//  r_almost_empty  out  1             level <= AE_THRESH
//  underflow       out  1             1-cycle pulse: read request rejected
//  level           out  ADDR_WIDTH+1  current word count, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x DATA_WIDTH array. Read/write pointers are ADDR_WIDTH+1 bits; low ADDR_WIDTH bits
//    address the array; the MSB disambiguates full/empty. Pointers wrap modulo 2*DEPTH, no special casing.
//  - Reset (rst_n=0 at posedge): pointers=0, level=0, r_empty=1, r_almost_empty=1, w_full=0,
//    w_almost_full=0 (1 if AF_THRESH... never <1, so 0), overflow=0, underflow=0, r_out=0. Array not cleared.
//    Reset mid-operation discards all contents; reset has priority over flush, w_en, r_en.
//  - flush=1 (rst_n=1): same as reset for pointers/level/flags; r_out holds; w_en/r_en that cycle ignored,
//    no overflow/underflow pulse.
//  - Accept rules, evaluated on registered flags at the posedge:
//      write accepted  = w_en & ~w_full;  read accepted = r_en & ~r_empty.
//    Full + w_en + r_en: read accepted, write rejected (overflow=1). No pass-through.
//    Empty + w_en + r_en: write accepted, read rejected (underflow=1).
//  - overflow = w_en & w_full, underflow = r_en & r_empty; registered, high for exactly the cycle after.
//  - level: +1 on write-only, -1 on read-only, unchanged on both or neither. All flags registered and
//    consistent with level after the same edge; never combinational from w_en/r_en.
//  - Write latency: word accepted at edge k counts in level and clears r_empty after edge k.
//  - FWFT=0: r_out registered; loads array[rd_addr] on the edge a read is accepted (1-cycle latency),
//    holds otherwise.
//  - FWFT=1: r_out continuously shows head word array[rd_addr]; valid whenever r_empty=0; r_en pops it,
//    next word visible after that edge. r_out is don't-care while r_empty=1.
//  - Ordering strictly FIFO; no word lost, duplicated or reordered across any pointer wrap.
// TESTING
//  1. Reset: hold rst_n=0 3 cycles with w_en=r_en=1 -> level=0, r_empty=1, w_full=0, no pulses; release.
//  2. Fill/drain DEPTH=16: write 0x0001..0x0010 -> w_full=1 after 16th edge, w_almost_full at level 14;
//     17th write -> overflow pulse, level stays 16; read 16 -> data 0x0001..0x0010 in order, r_empty=1.
//  3. Simultaneous: at level 5 assert w_en+r_en 10 cycles -> level stays 5; at full -> read ok, overflow=1;
//     at empty -> level 1, underflow=1.
//  4. Wrap: 3*DEPTH+7 words streamed with random w_en/r_en -> scoreboard matches, level never >16 or <0.
//  5. FWFT=1: write 0xABCD into empty -> r_out=0xABCD, r_empty=0 after that edge, before any r_en;
//     r_en pops -> r_empty=1.
//  6. Flush at level 9 with w_en=r_en=1 -> level=0, r_empty=1, no overflow/underflow, next write reads back.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// rtl/sync_fifo_ctl.sv - single-clock FIFO with fill level, thresholds, flush and FWFT option
//
// Ports:
//   clk            single clock, all logic on posedge
//   rst_n          synchronous reset, active low
//   flush          synchronous clear of contents, active high
//   w_en, w_in     write request and data
//   w_full         level == DEPTH
//   w_almost_full  level >= AF_THRESH
//   overflow       one-cycle pulse after a rejected write
//   r_en           read request (pop/acknowledge when FWFT=1)
//   r_out          read data (registered when FWFT=0, head word when FWFT=1)
//   r_empty        level == 0
//   r_almost_empty level <= AE_THRESH
//   underflow      one-cycle pulse after a rejected read
//   level          current word count, 0..DEPTH
module sync_fifo_ctl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic                  overflow,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_out,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The extra MSB on each pointer separates full from empty when the
    // address bits coincide; pointers simply wrap modulo 2*DEPTH.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH:0]   level_nxt;

    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // Acceptance uses the registered flags only, so a full FIFO never
    // passes a word straight through even when a read happens that cycle.
    assign wr_acc = w_en & ~w_full;
    assign rd_acc = r_en & ~r_empty;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + ONE_L;
            2'b01:   level_nxt = level - ONE_L;
            default: level_nxt = level;
        endcase
    end

    // Flags are computed from the next level so they agree with level
    // immediately after the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            w_full         <= 1'b0;
            w_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            w_full         <= 1'b0;
            w_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_L;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE_L;
            end
            level          <= level_nxt;
            w_full         <= (level_nxt == DEPTH_L);
            w_almost_full  <= (level_nxt >= AF_L);
            r_empty        <= (level_nxt == '0);
            r_almost_empty <= (level_nxt <= AE_L);
            overflow       <= w_en & w_full;
            underflow      <= r_en & r_empty;
        end
    end

    // Storage is never cleared; stale words are unreachable once the
    // pointers are reset.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_acc) begin
            mem[wr_addr] <= w_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always visible; meaningful only while r_empty=0.
            assign r_out = mem[rd_addr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_out_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out_q <= '0;
                end else if (!flush && rd_acc) begin
                    r_out_q <= mem[rd_addr];
                end
            end

            assign r_out = r_out_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb/tb_sync_fifo_ctl.sv - scoreboard testbench for sync_fifo_ctl (standard and FWFT instances)
module tb_sync_fifo_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        w_en = 1'b0;
    logic [15:0] w_in = 16'h0;
    logic        r_en = 1'b0;

    logic        w_full0, w_af0, ovf0, r_empty0, r_ae0, udf0;
    logic [15:0] r_out0;
    logic [4:0]  level0;

    logic        w_full1, w_af1, ovf1, r_empty1, r_ae1, udf1;
    logic [15:0] r_out1;
    logic [4:0]  level1;

    always #5 clk = ~clk;

    sync_fifo_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .w_en(w_en), .w_in(w_in), .w_full(w_full0), .w_almost_full(w_af0), .overflow(ovf0),
        .r_en(r_en), .r_out(r_out0), .r_empty(r_empty0), .r_almost_empty(r_ae0),
        .underflow(udf0), .level(level0)
    );

    sync_fifo_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .w_en(w_en), .w_in(w_in), .w_full(w_full1), .w_almost_full(w_af1), .overflow(ovf1),
        .r_en(r_en), .r_out(r_out1), .r_empty(r_empty1), .r_almost_empty(r_ae1),
        .underflow(udf1), .level(level1)
    );

    int total = 0;
    int bad = 0;

    logic [15:0] q[$];
    logic [15:0] exp_rout = 16'h0;
    logic [4:0]  exp_level;
    logic [5:0]  exp_flags;
    logic [5:0]  flags0;
    logic [5:0]  flags1;

    assign flags0 = {w_full0, w_af0, r_empty0, r_ae0, ovf0, udf0};
    assign flags1 = {w_full1, w_af1, r_empty1, r_ae1, ovf1, udf1};

    // Drives one cycle, advances the model with the pre-edge state, and
    // leaves expectations ready for sampling 1 time unit after the edge.
    task automatic tick(input logic we, input logic [15:0] wd, input logic re, input logic fl);
        int sz;
        logic ovf, udf;
        w_en = we;
        w_in = wd;
        r_en = re;
        flush = fl;
        @(posedge clk);
        sz = q.size();
        ovf = 1'b0;
        udf = 1'b0;
        if (!rst_n) begin
            q.delete();
            exp_rout = 16'h0;
        end else if (fl) begin
            q.delete();
        end else begin
            ovf = we && (sz == 16);
            udf = re && (sz == 0);
            if (re && sz > 0) exp_rout = q.pop_front();
            if (we && sz < 16) q.push_back(wd);
        end
        sz = q.size();
        exp_level = 5'(sz);
        exp_flags = {sz == 16, sz >= 14, sz == 0, sz <= 1, ovf, udf};
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'hFFFF, 1'b1, 1'b0);
            total++;
            if (level0 !== 5'd0 || flags0 !== 6'b001100 || r_out0 !== 16'h0) begin
                bad++;
                $display("FAIL reset cyc%0d: level=%0d flags=%b r_out=%h, want level=0 flags=001100 r_out=0000",
                         i, level0, flags0, r_out0);
            end
        end
        rst_n = 1'b1;
        tick(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, 16'(i), 1'b0, 1'b0);
            total++;
            if (level0 !== exp_level || flags0 !== exp_flags) begin
                bad++;
                $display("FAIL fill%0d: level=%0d flags=%b, want level=%0d flags=%b",
                         i, level0, flags0, exp_level, exp_flags);
            end
        end
        total++;
        if (w_full0 !== 1'b1) begin
            bad++;
            $display("FAIL full_after_16: w_full=%b, want 1", w_full0);
        end
        tick(1'b1, 16'h0011, 1'b0, 1'b0);
        total++;
        if (ovf0 !== 1'b1 || level0 !== 5'd16) begin
            bad++;
            $display("FAIL overflow17: overflow=%b level=%0d, want overflow=1 level=16", ovf0, level0);
        end
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 16'h0, 1'b1, 1'b0);
            total++;
            if (r_out0 !== exp_rout || r_out0 !== 16'(i) || level0 !== exp_level || flags0 !== exp_flags) begin
                bad++;
                $display("FAIL drain%0d: r_out=%h level=%0d flags=%b, want r_out=%h level=%0d flags=%b",
                         i, r_out0, level0, flags0, 16'(i), exp_level, exp_flags);
            end
        end
        total++;
        if (r_empty0 !== 1'b1) begin
            bad++;
            $display("FAIL empty_after_drain: r_empty=%b, want 1", r_empty0);
        end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 5; i++) tick(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 16'h0200 + 16'(i), 1'b1, 1'b0);
            total++;
            if (level0 !== 5'd5 || r_out0 !== exp_rout || flags0 !== exp_flags) begin
                bad++;
                $display("FAIL both_at5 cyc%0d: level=%0d r_out=%h flags=%b, want level=5 r_out=%h flags=%b",
                         i, level0, r_out0, flags0, exp_rout, exp_flags);
            end
        end
        for (int i = 0; i < 11; i++) tick(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
        tick(1'b1, 16'h0EEE, 1'b1, 1'b0);
        total++;
        if (level0 !== 5'd15 || ovf0 !== 1'b1 || udf0 !== 1'b0 || r_out0 !== exp_rout) begin
            bad++;
            $display("FAIL both_at_full: level=%0d overflow=%b underflow=%b r_out=%h, want 15 1 0 %h",
                     level0, ovf0, udf0, r_out0, exp_rout);
        end
        for (int i = 0; i < 15; i++) tick(1'b0, 16'h0, 1'b1, 1'b0);
        tick(1'b1, 16'h0777, 1'b1, 1'b0);
        total++;
        if (level0 !== 5'd1 || udf0 !== 1'b1 || ovf0 !== 1'b0 || r_empty0 !== 1'b0) begin
            bad++;
            $display("FAIL both_at_empty: level=%0d underflow=%b overflow=%b r_empty=%b, want 1 1 0 0",
                     level0, udf0, ovf0, r_empty0);
        end
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        total++;
        if (udf0 !== 1'b0) begin
            bad++;
            $display("FAIL underflow_one_cycle: underflow=%b, want 0", udf0);
        end
    endtask

    task automatic test_wrap;
        int written;
        int cyc;
        logic we, re;
        written = 0;
        cyc = 0;
        while (written < 3 * 16 + 7 && cyc < 3000) begin
            we = ($urandom_range(0, 99) < 60);
            re = ($urandom_range(0, 99) < 50);
            if (we && q.size() < 16) written++;
            tick(we, 16'($urandom), re, 1'b0);
            cyc++;
            total++;
            if (level0 !== exp_level || flags0 !== exp_flags || r_out0 !== exp_rout || level0 > 5'd16) begin
                bad++;
                $display("FAIL wrap cyc%0d: level=%0d flags=%b r_out=%h, want level=%0d flags=%b r_out=%h",
                         cyc, level0, flags0, r_out0, exp_level, exp_flags, exp_rout);
            end
            if (q.size() > 0) begin
                total++;
                if (r_out1 !== q[0] || level1 !== exp_level) begin
                    bad++;
                    $display("FAIL wrap_fwft cyc%0d: head=%h level=%0d, want head=%h level=%0d",
                             cyc, r_out1, level1, q[0], exp_level);
                end
            end
        end
        total++;
        if (written < 3 * 16 + 7) begin
            bad++;
            $display("FAIL wrap_budget: written=%0d, want 55", written);
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 64) begin
            tick(1'b0, 16'h0, 1'b1, 1'b0);
            cyc++;
            total++;
            if (r_out0 !== exp_rout || level0 !== exp_level) begin
                bad++;
                $display("FAIL wrap_drain: r_out=%h level=%0d, want r_out=%h level=%0d",
                         r_out0, level0, exp_rout, exp_level);
            end
        end
    endtask

    task automatic test_fwft;
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        tick(1'b1, 16'hABCD, 1'b0, 1'b0);
        total++;
        if (r_out1 !== 16'hABCD || r_empty1 !== 1'b0) begin
            bad++;
            $display("FAIL fwft_show: r_out=%h r_empty=%b, want abcd 0", r_out1, r_empty1);
        end
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        total++;
        if (r_empty1 !== 1'b1 || level1 !== 5'd0) begin
            bad++;
            $display("FAIL fwft_pop: r_empty=%b level=%0d, want 1 0", r_empty1, level1);
        end
        tick(1'b1, 16'h1234, 1'b0, 1'b0);
        tick(1'b1, 16'h5678, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        total++;
        if (r_out1 !== 16'h5678 || r_empty1 !== 1'b0) begin
            bad++;
            $display("FAIL fwft_next: r_out=%h r_empty=%b, want 5678 0", r_out1, r_empty1);
        end
        tick(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush;
        logic [15:0] held;
        for (int i = 0; i < 9; i++) tick(1'b1, 16'h0900 + 16'(i), 1'b0, 1'b0);
        held = exp_rout;
        tick(1'b1, 16'hDEAD, 1'b1, 1'b1);
        total++;
        if (level0 !== 5'd0 || flags0 !== 6'b001100 || r_out0 !== held) begin
            bad++;
            $display("FAIL flush: level=%0d flags=%b r_out=%h, want level=0 flags=001100 r_out=%h",
                     level0, flags0, r_out0, held);
        end
        tick(1'b1, 16'h5A5A, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        total++;
        if (r_out0 !== 16'h5A5A || r_empty0 !== 1'b1) begin
            bad++;
            $display("FAIL flush_readback: r_out=%h r_empty=%b, want 5a5a 1", r_out0, r_empty0);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
